// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 4-digit 7-segment scan driver.
//   NUM_DIGITS   : digits scanned per frame
//   DIG_OFF      : active-low digit enables, all digits dark
//   DP_OFF       : active-low decimal point, unlit
//   slot_state_t : per-slot phase (guard band / digit lit)
//   disp_t       : one displayable frame (dp bits + 4 nibbles)
//   lz_blank_mask: which of digits 3..1 are leading zeros to suppress
package seg7_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIG_OFF    = 4'b1111;
  localparam logic       DP_OFF     = 1'b1;

  typedef enum logic {S_GUARD, S_ON} slot_state_t;

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] val;
  } disp_t;

  // Digit i is a leading zero when it and every digit to its left are 0,
  // unless its dp is requested (a lit dp must stay visible). Digit 0 always shows.
  function automatic logic [3:0] lz_blank_mask(input disp_t d, input logic en);
    logic [3:0] m;
    m = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      m[i] = en && ((d.val >> (4 * i)) == 16'h0000) && !d.dp[i];
    return m;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: digit-slot prescaler and slot FSM.
//   clk, rst    : clock, async active-high reset
//   idx_o       : digit index currently scanned (0..3)
//   state_o     : S_GUARD for the first GUARD cycles of a slot, S_ON afterwards
//   frame_end_o : last cycle of the digit-3 slot (frame boundary)
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        rst,
  output logic [1:0]  idx_o,
  output slot_state_t state_o,
  output logic        frame_end_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'((GUARD > 0) ? GUARD - 1 : 0);
  // Every slot starts in this state; with no guard band the slot is lit at once.
  localparam slot_state_t SLOT_START = (GUARD == 0) ? S_ON : S_GUARD;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  slot_state_t   state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      state_q <= SLOT_START;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      state_d = SLOT_START;
    end else if (state_q == S_GUARD && presc_q == GUARD_LAST) begin
      state_d = S_ON;
    end
  end

  assign idx_o       = idx_q;
  assign state_o     = state_q;
  assign frame_end_o = (idx_q == 2'd3) && (presc_q == PRESC_LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 4-digit scan stage feeding a 7-segment decoder.
//   clk, rst    : clock, async active-high reset
//   load        : strobe, stage value_in/dp_in for the next frame
//   value_in    : 4 nibbles, [3:0] = rightmost digit 0
//   dp_in       : dp request per digit, 1 = lit
//   lz_blank_en : suppress leading-zero digits 3..1 (live, not shadowed)
//   nibble      : nibble of the digit being scanned, to the decoder
//   dig_n       : active-low digit anode enables
//   dp_out      : active-low decimal point
//   frame_tick  : 1-cycle pulse after each frame boundary
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank_en,
  output logic [3:0]  nibble,
  output logic [3:0]  dig_n,
  output logic        dp_out,
  output logic        frame_tick
);

  logic [1:0]  idx;
  slot_state_t state;
  logic        frame_end;

  seg7_slot_timer #(.DIV(DIV), .GUARD(GUARD)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .idx_o       (idx),
    .state_o     (state),
    .frame_end_o (frame_end)
  );

  // staged collects loads mid-frame; shadow is what the scan displays and only
  // changes on the frame boundary, so one frame never mixes two values.
  disp_t staged_q, staged_d, shadow_q, shadow_d, in_w;
  logic  pending_q, pending_d;

  logic [3:0] nibble_q, nibble_d, dig_n_q, dig_n_d;
  logic       dp_q, dp_d, tick_q;
  logic [3:0] blank;

  assign in_w = '{dp: dp_in, val: value_in};

  always_comb begin
    staged_d  = staged_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (load) begin
      staged_d  = in_w;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      // A load landing on the boundary itself bypasses staging.
      if (load) begin
        shadow_d  = in_w;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = staged_q;
        pending_d = 1'b0;
      end
    end
  end

  assign blank = lz_blank_mask(shadow_q, lz_blank_en);

  always_comb begin
    nibble_d = shadow_q.val[4*idx +: 4];
    dig_n_d  = DIG_OFF;
    dp_d     = DP_OFF;
    if (state == S_ON && !blank[idx]) begin
      dig_n_d = ~(4'b0001 << idx);
      dp_d    = ~shadow_q.dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staged_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      nibble_q  <= '0;
      dig_n_q   <= DIG_OFF;
      dp_q      <= DP_OFF;
      tick_q    <= 1'b0;
    end else begin
      staged_q  <= staged_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      nibble_q  <= nibble_d;
      dig_n_q   <= dig_n_d;
      dp_q      <= dp_d;
      tick_q    <= frame_end;
    end
  end

  assign nibble     = nibble_q;
  assign dig_n      = dig_n_q;
  assign dp_out     = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: main instance DIV=8/GUARD=2, second instance DIV=4/GUARD=0.
// k counts rising edges since reset release; sampling is on the falling edge.
// For the main instance, sample k shows the slot state of the previous cycle:
// digit ((k-1)/8)%4, lit when (k-1)%8 >= 2, frame boundary capture at k%32==0.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, lz_blank_en;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  nibble, dig_n;
  logic        dp_out, frame_tick;

  logic        load6, lz6;
  logic [15:0] val6;
  logic [3:0]  dp6;
  logic [3:0]  nibble6, dig_n6;
  logic        dp_out6, tick6;

  int k = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
    .lz_blank_en(lz_blank_en), .nibble(nibble), .dig_n(dig_n),
    .dp_out(dp_out), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(.DIV(4), .GUARD(0)) u6 (
    .clk(clk), .rst(rst), .load(load6), .value_in(val6), .dp_in(dp6),
    .lz_blank_en(lz6), .nibble(nibble6), .dig_n(dig_n6),
    .dp_out(dp_out6), .frame_tick(tick6)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic drv(input logic [15:0] v, input logic [3:0] dp);
    load = 1'b1; value_in = v; dp_in = dp;
  endtask

  // One clock, then check the main instance against the displayed value v,
  // the digits expected to light (mask) and the dp pattern.
  task automatic cyc(input logic [15:0] v, input logic [3:0] mask, input logic [3:0] dpm);
    int d, p;
    logic [3:0] ed;
    logic       edp;
    @(negedge clk);
    k++;
    d = ((k - 1) / 8) % 4;
    p = (k - 1) % 8;
    if (p >= 2 && mask[d]) begin
      ed  = ~(4'b0001 << d);
      edp = ~dpm[d];
    end else begin
      ed  = 4'hF;
      edp = 1'b1;
    end
    chk("dig_n", {12'h0, dig_n}, {12'h0, ed});
    chk("nibble", {12'h0, nibble}, {12'h0, v[4*d +: 4]});
    chk("dp_out", {15'h0, dp_out}, {15'h0, edp});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, (k % 32 == 0)});
  endtask

  // n cycles of checks, with up to two loads issued after given samples (-1 = none).
  task automatic run(input int n, input logic [15:0] v, input logic [3:0] mask,
                     input logic [3:0] dpm, input int k1, input logic [15:0] v1,
                     input logic [3:0] d1, input int k2, input logic [15:0] v2,
                     input logic [3:0] d2);
    for (int i = 0; i < n; i++) begin
      cyc(v, mask, dpm);
      load = 1'b0;
      if (k == k1) drv(v1, d1);
      else if (k == k2) drv(v2, d2);
    end
  endtask

  initial begin
    logic [15:0] a6;
    logic [3:0]  e6;
    int d6;
    a6 = 16'hABCD;
    rst = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; lz_blank_en = 1'b0;
    load6 = 1'b0; val6 = '0; dp6 = '0; lz6 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dig_n", {12'h0, dig_n}, 16'h000F);
    chk("rst_nibble", {12'h0, nibble}, 16'h0000);
    chk("rst_dp", {15'h0, dp_out}, 16'h0001);
    chk("rst_tick", {15'h0, frame_tick}, 16'h0000);
    rst = 1'b0;
    k = 0;

    // F0: reset shadow 0, first lit at k=3 on digit 0; stage 0x1234
    run(32, 16'h0000, 4'hF, 4'h0, 5, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
    // F1: 0x1234 all lit; stage 0x0042
    run(32, 16'h1234, 4'hF, 4'h0, 40, 16'h0042, 4'h0, -1, 16'h0, 4'h0);
    lz_blank_en = 1'b1;
    // F2: 0x0042 leading zeros blanked; stage 0x0000
    run(32, 16'h0042, 4'h3, 4'h0, 70, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
    // F3: 0x0000 only digit 0; stage 0 with dp on digit 3
    run(32, 16'h0000, 4'h1, 4'h0, 100, 16'h0000, 4'h8, -1, 16'h0, 4'h0);
    // F4: dp keeps digit 3 lit; loads in digit-1 then digit-2 slot, last wins
    run(32, 16'h0000, 4'h9, 4'h8, 138, 16'hAAAA, 4'h0, 148, 16'hBBBB, 4'h0);
    lz_blank_en = 1'b0;
    // F5: 0xBBBB; pending 0x1111, then 0x5678 loaded on the boundary cycle
    run(32, 16'hBBBB, 4'hF, 4'h0, 170, 16'h1111, 4'h0, 191, 16'h5678, 4'h0);
    // F6/F7: bypass won and pending was cleared
    run(32, 16'h5678, 4'hF, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run(12, 16'h5678, 4'hF, 4'h0, 230, 16'h9999, 4'h0, -1, 16'h0, 4'h0);

    // Mid-scan asynchronous reset (digit 1 lit just before)
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dig_n", {12'h0, dig_n}, 16'h000F);
    chk("mid_rst_nibble", {12'h0, nibble}, 16'h0000);
    chk("mid_rst_dp", {15'h0, dp_out}, 16'h0001);
    chk("mid_rst_tick", {15'h0, frame_tick}, 16'h0000);
    chk("mid_rst_dig_n6", {12'h0, dig_n6}, 16'h000F);
    @(negedge clk);
    rst = 1'b0;
    k = 0;

    // Staged 0x9999 was discarded: two frames of 0. Alongside, the no-guard
    // instance is lit every cycle, 4 cycles per digit, 0xABCD from its 2nd frame.
    for (int i = 0; i < 64; i++) begin
      cyc(16'h0000, 4'hF, 4'h0);
      load6 = 1'b0;
      if (k <= 32) begin
        d6 = ((k - 1) / 4) % 4;
        e6 = ~(4'b0001 << d6);
        chk("t6_dig_n", {12'h0, dig_n6}, {12'h0, e6});
        chk("t6_nibble", {12'h0, nibble6}, (k <= 16) ? 16'h0 : {12'h0, a6[4*d6 +: 4]});
        chk("t6_tick", {15'h0, tick6}, {15'h0, (k % 16 == 0)});
      end
      if (k == 1) begin
        load6 = 1'b1; val6 = a6;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
